// File: rtl/sort_pkg.sv
// Shared definitions for the RAM bubble sorter: FSM state encoding,
// swap-counter width and a RAM depth helper.
package sort_pkg;

  // Sort engine FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CMP   = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_DONE  = 3'd5
  } sort_state_e;

  localparam int SWAP_CNT_W = 16;
  localparam logic [SWAP_CNT_W-1:0] SWAP_CNT_MAX = 16'hFFFF;

  // Number of RAM words addressed by an address bus of the given width
  function automatic int sort_depth(input int address_w);
    return 32'sd1 << address_w;
  endfunction

endpackage

// File: rtl/ram_bubble_sorter_if.sv
// Control and RAM-port bundle of the bubble sorter.
// master: the sort engine (drives the RAM ports, reports status).
// slave : the RAM / controller side.
interface ram_bubble_sorter_if #(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 4
);
  import sort_pkg::*;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [SWAP_CNT_W-1:0] swaps;
  logic                  en1;
  logic                  w_en1;
  logic [WIDTH-1:0]      w_data1;
  logic [ADDRESS-1:0]    addr1;
  logic [WIDTH-1:0]      r_data1;
  logic [ADDRESS-1:0]    addr2;
  logic [WIDTH-1:0]      r_data2;

  modport master (
    input  start, r_data1, r_data2,
    output busy, done, swaps, en1, w_en1, w_data1, addr1, addr2
  );

  modport slave (
    output start, r_data1, r_data2,
    input  busy, done, swaps, en1, w_en1, w_data1, addr1, addr2
  );

endinterface

// File: rtl/sort_cmp_swap.sv
// Compare-and-order cell: flags when a pair is out of ascending unsigned
// order and presents the pair sorted as lo/hi. Equal values never swap.
module sort_cmp_swap #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             swap_needed,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  // Strict unsigned compare and pair ordering
  always_comb begin
    swap_needed = (a > b);
    if (swap_needed) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/ram_bubble_sorter.sv
// In-place bubble sort engine for a two-port RAM (port 1 read/write,
// port 2 read-only, both with one-cycle read latency). Only the current
// pair is held; every element access goes through the RAM ports.
// All outputs are registered: each is computed from the next FSM state,
// so en1/addr/w_data are valid during the state that owns them.
// Optional feature: define SORTER_EARLY_EXIT_EN to stop after a pass that
// made no swaps; otherwise all N-1 passes always run.
module ram_bubble_sorter #(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 4
) (
  input logic                 clk,
  input logic                 reset,
  ram_bubble_sorter_if.master bus
);
  import sort_pkg::*;

  localparam logic [ADDRESS-1:0] ADDR_ZERO = ADDRESS'(0);
  localparam logic [ADDRESS-1:0] ADDR_ONE  = ADDRESS'(1);
  localparam logic [ADDRESS-1:0] LAST_INIT = ADDRESS'(sort_depth(ADDRESS) - 2);
  localparam logic [SWAP_CNT_W-1:0] SWAP_ONE = SWAP_CNT_W'(1);

  // FSM and datapath state
  sort_state_e           state_r, state_s;
  logic [ADDRESS-1:0]    i_r, i_s;
  logic [ADDRESS-1:0]    last_r, last_s;
  logic                  swapped_r, swapped_s;
  logic [WIDTH-1:0]      hi_r, hi_s;
  logic [SWAP_CNT_W-1:0] swaps_r, swaps_s;

  // Registered outputs
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  en1_r, en1_s;
  logic                  w_en1_r, w_en1_s;
  logic [WIDTH-1:0]      w_data1_r, w_data1_s;
  logic [ADDRESS-1:0]    addr1_r, addr1_s;
  logic [ADDRESS-1:0]    addr2_r, addr2_s;

  // Pair compare results and end-of-pair advance targets
  logic                  swap_needed_s;
  logic [WIDTH-1:0]      lo_cmp_s;
  logic [WIDTH-1:0]      hi_cmp_s;
  logic                  early_exit_s;
  sort_state_e           adv_state_s;
  logic [ADDRESS-1:0]    adv_i_s;
  logic [ADDRESS-1:0]    adv_last_s;
  logic                  adv_new_pass_s;

  // The pair read in READ is on r_data1/r_data2 during CMP
  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a           (bus.r_data1),
    .b           (bus.r_data2),
    .swap_needed (swap_needed_s),
    .lo          (lo_cmp_s),
    .hi          (hi_cmp_s)
  );

`ifdef SORTER_EARLY_EXIT_EN
  assign early_exit_s = ~swapped_r;
`else
  // The per-pass flag is still tracked but never ends the sort early.
  assign early_exit_s = 1'b0 & ~swapped_r;
`endif

  // Where to go once the current pair is finished (next pair or next pass)
  always_comb begin
    adv_state_s    = ST_READ;
    adv_i_s        = i_r;
    adv_last_s     = last_r;
    adv_new_pass_s = 1'b0;
    if (i_r < last_r) begin
      adv_state_s = ST_READ;
      adv_i_s     = i_r + ADDR_ONE;
    end else if ((last_r == ADDR_ZERO) || early_exit_s) begin
      adv_state_s = ST_DONE;
    end else begin
      adv_state_s    = ST_READ;
      adv_i_s        = ADDR_ZERO;
      adv_last_s     = last_r - ADDR_ONE;
      adv_new_pass_s = 1'b1;
    end
  end

  // Next-state, datapath updates and next output values
  always_comb begin
    state_s   = state_r;
    i_s       = i_r;
    last_s    = last_r;
    swapped_s = swapped_r;
    hi_s      = hi_r;
    swaps_s   = swaps_r;
    en1_s     = 1'b0;
    w_en1_s   = 1'b0;
    w_data1_s = w_data1_r;
    addr1_s   = addr1_r;
    addr2_s   = addr2_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          i_s       = ADDR_ZERO;
          last_s    = LAST_INIT;
          swapped_s = 1'b0;
          swaps_s   = '0;
          state_s   = ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_CMP;
      end
      ST_CMP: begin
        hi_s = hi_cmp_s;
        if (swap_needed_s) begin
          state_s = ST_WR_LO;
        end else begin
          state_s   = adv_state_s;
          i_s       = adv_i_s;
          last_s    = adv_last_s;
          swapped_s = adv_new_pass_s ? 1'b0 : swapped_r;
        end
      end
      ST_WR_LO: begin
        swapped_s = 1'b1;
        swaps_s   = (swaps_r == SWAP_CNT_MAX) ? swaps_r : swaps_r + SWAP_ONE;
        state_s   = ST_WR_HI;
      end
      ST_WR_HI: begin
        state_s   = adv_state_s;
        i_s       = adv_i_s;
        last_s    = adv_last_s;
        swapped_s = adv_new_pass_s ? 1'b0 : swapped_r;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // RAM port values for the state being entered
    case (state_s)
      ST_READ: begin
        en1_s   = 1'b1;
        addr1_s = i_s;
        addr2_s = i_s + ADDR_ONE;
      end
      ST_WR_LO: begin
        en1_s     = 1'b1;
        w_en1_s   = 1'b1;
        addr1_s   = i_s;
        w_data1_s = lo_cmp_s;
      end
      ST_WR_HI: begin
        en1_s     = 1'b1;
        w_en1_s   = 1'b1;
        addr1_s   = i_s + ADDR_ONE;
        w_data1_s = hi_r;
      end
      default: begin
        en1_s   = 1'b0;
        w_en1_s = 1'b0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      i_r       <= ADDR_ZERO;
      last_r    <= LAST_INIT;
      swapped_r <= 1'b0;
      hi_r      <= '0;
      swaps_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      en1_r     <= 1'b0;
      w_en1_r   <= 1'b0;
      w_data1_r <= '0;
      addr1_r   <= ADDR_ZERO;
      addr2_r   <= ADDR_ZERO;
    end else begin
      state_r   <= state_s;
      i_r       <= i_s;
      last_r    <= last_s;
      swapped_r <= swapped_s;
      hi_r      <= hi_s;
      swaps_r   <= swaps_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      en1_r     <= en1_s;
      w_en1_r   <= w_en1_s;
      w_data1_r <= w_data1_s;
      addr1_r   <= addr1_s;
      addr2_r   <= addr2_s;
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.swaps   = swaps_r;
  assign bus.en1     = en1_r;
  assign bus.w_en1   = w_en1_r;
  assign bus.w_data1 = w_data1_r;
  assign bus.addr1   = addr1_r;
  assign bus.addr2   = addr2_r;

endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Bench for ram_bubble_sorter: behavioural two-port RAM, write-pair monitor,
// table of preload/expected vectors, plus start-while-busy and reset-mid-sort
// sequences. Expected cycle counts follow SORTER_EARLY_EXIT_EN.
module tb_ram_bubble_sorter;

  localparam int W = 16;
  localparam int A = 4;
  localparam int N = 16;
`ifdef SORTER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_bubble_sorter_if #(.WIDTH(W), .ADDRESS(A)) bus ();

  ram_bubble_sorter #(.WIDTH(W), .ADDRESS(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Two-port RAM model with a bench-side preload path
  logic [W-1:0] mem [N];
  logic         load_en;
  logic [A-1:0] load_addr;
  logic [W-1:0] load_data;

  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    else if (bus.en1 && bus.w_en1) mem[bus.addr1] <= bus.w_data1;
    if (bus.en1 && !bus.w_en1) bus.r_data1 <= mem[bus.addr1];
    bus.r_data2 <= mem[bus.addr2];
  end

  // Activity monitor: counts reads/writes/done and checks each write pair
  int           n_reads, n_writes, n_done, wr_err;
  logic         mon_clr;
  logic         in_pair;
  logic [W-1:0] exp_hi;
  logic [A-1:0] lo_addr;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_reads  <= 0;
      n_writes <= 0;
      n_done   <= 0;
      wr_err   <= 0;
      in_pair  <= 1'b0;
    end else begin
      if (bus.done) n_done <= n_done + 1;
      if (bus.en1 && !bus.w_en1) n_reads <= n_reads + 1;
      if (bus.en1 && bus.w_en1) begin
        n_writes <= n_writes + 1;
        if (!in_pair) begin
          if (bus.w_data1 !== mem[bus.addr1 + 4'd1] ||
              !(mem[bus.addr1] > mem[bus.addr1 + 4'd1]))
            wr_err <= wr_err + 1;
          exp_hi  <= mem[bus.addr1];
          lo_addr <= bus.addr1;
          in_pair <= 1'b1;
        end else begin
          if (bus.addr1 !== lo_addr + 4'd1 || bus.w_data1 !== exp_hi)
            wr_err <= wr_err + 1;
          in_pair <= 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_mem(input logic [0:N-1][W-1:0] din);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = A'(k);
      load_data = din[k];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Pulse start, optionally pulse it again at restart_at, and wait for done
  task automatic run_sort(input int restart_at, output int done_cyc, output bit busy_ok);
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      if (c == 1 && !bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      if (c == restart_at) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end
    @(posedge clk);
    #1;
    if (bus.busy) busy_ok = 1'b0;
  endtask

  function automatic logic [N*W-1:0] mem_image();
    logic [0:N-1][W-1:0] img;
    for (int k = 0; k < N; k++) img[k] = mem[k];
    return img;
  endfunction

  function automatic logic [N*W-1:0] out_image();
    return {bus.busy, bus.done, bus.en1, bus.w_en1, bus.swaps, bus.w_data1, bus.addr1, bus.addr2};
  endfunction

  typedef struct {
    logic [0:N-1][W-1:0] din;
    logic [0:N-1][W-1:0] dexp;
    int swaps;
    int reads_ee;
    int reads_all;
    int done_ee;
    int done_all;
  } vec_t;

  vec_t vecs [5];
  logic [0:N-1][W-1:0] ascending;
  logic [0:N-1][W-1:0] after_reset;

  initial begin
    int  dc;
    bit  bok;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    mon_clr   = 1'b0;
    bus.start = 1'b0;
    reset     = 1'b1;

    for (int k = 0; k < N; k++) ascending[k] = W'(k);
    // 0: already sorted
    vecs[0].din = ascending; vecs[0].dexp = ascending;
    vecs[0].swaps = 0;   vecs[0].reads_ee = 15;  vecs[0].reads_all = 120;
    vecs[0].done_ee = 31; vecs[0].done_all = 241;
    // 1: reverse order
    for (int k = 0; k < N; k++) vecs[1].din[k] = W'(15 - k);
    vecs[1].dexp = ascending;
    vecs[1].swaps = 120; vecs[1].reads_ee = 120; vecs[1].reads_all = 120;
    vecs[1].done_ee = 481; vecs[1].done_all = 481;
    // 2: all equal
    for (int k = 0; k < N; k++) vecs[2].din[k] = 16'h0007;
    vecs[2].dexp = vecs[2].din;
    vecs[2].swaps = 0;   vecs[2].reads_ee = 15;  vecs[2].reads_all = 120;
    vecs[2].done_ee = 31; vecs[2].done_all = 241;
    // 3: duplicates and max values (36 inversions, 5 passes with early exit)
    vecs[3].din  = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0002,
                     16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};
    vecs[3].dexp = '{16'h0000, 16'h0000, 16'h0001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
                     16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[3].swaps = 36;  vecs[3].reads_ee = 65;  vecs[3].reads_all = 120;
    vecs[3].done_ee = 203; vecs[3].done_all = 313;
    // 4: adjacent pairs swapped (8 swaps, 2 passes with early exit)
    for (int k = 0; k < N; k++) vecs[4].din[k] = W'(k ^ 1);
    vecs[4].dexp = ascending;
    vecs[4].swaps = 8;   vecs[4].reads_ee = 29;  vecs[4].reads_all = 120;
    vecs[4].done_ee = 75; vecs[4].done_all = 257;

    repeat (3) @(posedge clk);
    #1 check("reset outputs", out_image(), '0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      load_mem(vecs[v].din);
      run_sort(-1, dc, bok);
      check($sformatf("v%0d done cycle", v), dc, EE ? vecs[v].done_ee : vecs[v].done_all);
      check($sformatf("v%0d swaps", v), bus.swaps, vecs[v].swaps);
      check($sformatf("v%0d compares", v), n_reads, EE ? vecs[v].reads_ee : vecs[v].reads_all);
      check($sformatf("v%0d writes", v), n_writes, 2 * vecs[v].swaps);
      check($sformatf("v%0d done pulses", v), n_done, 1);
      check($sformatf("v%0d write pair errors", v), wr_err, 0);
      check($sformatf("v%0d busy window", v), bok, 1);
      check($sformatf("v%0d ram contents", v), mem_image(), vecs[v].dexp);
    end

    // start pulsed again while busy: no restart, swaps keep counting
    load_mem(vecs[1].din);
    run_sort(10, dc, bok);
    check("busy start done cycle", dc, 481);
    check("busy start swaps", bus.swaps, 120);
    check("busy start done pulses", n_done, 1);
    check("busy start ram", mem_image(), ascending);
    repeat (3) @(posedge clk);
    #1 check("no restart after done", bus.busy, 0);

    // asynchronous reset in the middle of cycle 50 (CMP of the 13th pair)
    load_mem(vecs[1].din);
    clear_mon();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (49) begin
      @(posedge clk);
      #1;
    end
    check("swaps before reset", bus.swaps, 12);
    #3 reset = 1'b1;
    #1 check("outputs on mid-sort reset", out_image(), '0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) after_reset[k] = W'(14 - k);
    after_reset[12] = 16'd15;
    after_reset[13] = 16'd2;
    after_reset[14] = 16'd1;
    after_reset[15] = 16'd0;
    check("ram after reset", mem_image(), after_reset);
    run_sort(-1, dc, bok);
    check("resort done cycle", dc, 457);
    check("resort swaps", bus.swaps, 108);
    check("resort ram", mem_image(), ascending);
    check("resort write pair errors", wr_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
